multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: SHAMT_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  command valid.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 alu_control_lines  input  4  operation code from the ALU control decoder.
REQ-008 operand_a  input  WIDTH  first operand.
REQ-009 operand_b  input  WIDTH  second operand; bits [SHAMT_W-1:0] are the shift amount.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  high when result equals 0.
REQ-014 illegal  output  1  high when the captured code is unsupported.

Function
REQ-015 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRA, 0110 SUB, 0111 SRL.
REQ-016 Any other code, including 1111, SHALL give result 0, illegal=1 and zero=1.
REQ-017 ADD and SUB SHALL wrap modulo 2^WIDTH. No carry or overflow output exists.
REQ-018 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-019 in_ready SHALL be high only in IDLE. A command is accepted on a cycle with in_valid and in_ready both high.
REQ-020 On acceptance, the code, operand_a and shift amount SHALL be registered. Later input changes SHALL have no effect on the command in flight.
REQ-021 Non-shift op accepted at edge N: IDLE->DONE. The result is registered at edge N, so out_valid is high in the cycle after the accepting cycle (latency 1).
REQ-022 Shift op with amount 0: IDLE->DONE with result equal to operand_a (latency 1).
REQ-023 Shift op with amount k>0: IDLE->SHIFT. The block shifts by 1 bit per cycle and decrements a counter.
REQ-024 SHIFT->DONE SHALL occur on the edge that performs the last bit shift, so out_valid rises k+1 cycles after acceptance.
REQ-025 SRA SHALL replicate the sign bit on every step. SRL and SLL SHALL fill with 0.
REQ-026 In DONE, result, zero, illegal and out_valid SHALL hold stable until out_ready is high.
REQ-027 DONE with out_ready high: transition to IDLE and drop out_valid on that edge. There is no same-cycle re-accept, so the peak rate is 1 command per 2 cycles.
REQ-028 out_ready SHALL be ignored outside DONE. in_valid SHALL be ignored outside IDLE.
REQ-029 zero SHALL be derived from the registered result and be valid whenever out_valid is high.

Reset
REQ-030 When rst_n is low, the FSM SHALL go to IDLE asynchronously with all datapath registers cleared.
REQ-031 Reset outputs SHALL be: out_valid=0, result=0, zero=1, illegal=0, in_ready=1 (after deassertion).
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL discard the command with no result delivered.
REQ-033 rst_n deassertion SHALL be synchronised externally. The first command may be accepted on the first edge after release.

Structure
REQ-034 Shared package alu_pkg SHALL hold the 4-bit operation-code constants and the FSM state typedef.
REQ-035 Package constants SHALL be shared with the ALU control decoder so the codes match in both blocks.
REQ-036 One sub-module, alu_logic_unit, SHALL hold the combinational AND/OR/XOR/ADD/SUB datapath. Shift iteration stays in multicycle_alu.

Verification
REQ-037 ADD 0xFFFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, result 0x00000000, zero=1.
REQ-038 SUB 5 - 7 -> result 0xFFFFFFFE, zero=0, illegal=0.
REQ-039 SRA 0x80000000 by 4 -> out_valid 5 cycles after accept, result 0xF8000000. SRL on the same inputs -> 0x08000000.
REQ-040 SLL 0x00000001 by 31 -> 32-cycle latency, result 0x80000000. Change operand_a during SHIFT -> no effect.
REQ-041 Code 1111 -> result 0, illegal=1. Hold out_ready low 3 cycles -> outputs stable. Assert out_ready -> IDLE, in_ready=1 the next cycle.
REQ-042 Assert rst_n low during SHIFT of SLL by 10 -> out_valid=0 and in_ready=1 immediately after release. A following AND 0xF0 & 0x3C returns 0x30.

Source files
------------

// File: rtl/alu_pkg.sv
// Operation codes and FSM state type shared by the multicycle ALU
// and the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op[3] == 1'b0;
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Single-cycle AND/OR/XOR/ADD/SUB datapath; any other code yields 0.
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: logic ops in one cycle, shifts iterate one bit
// per cycle in the result register.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control_lines,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               ill_q, ill_d;

    logic [WIDTH-1:0]   lu_y;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               go_shift;

    assign shamt    = operand_b[SHAMT_W-1:0];
    assign accept   = in_valid && (state_q == ST_IDLE);
    assign go_shift = is_shift(alu_control_lines) && (shamt != '0);

    alu_logic_unit #(.WIDTH(WIDTH)) u_logic (
        .op_i (alu_control_lines),
        .a_i  (operand_a),
        .b_i  (operand_b),
        .y_o  (lu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = go_shift ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = res_q;
        zero      = (res_q == '0);
        illegal   = ill_q;
    end

    // Shifts load operand_a into the result register and shift it in place.
    always_comb begin
        op_d  = op_q;
        res_d = res_q;
        cnt_d = cnt_q;
        ill_d = ill_q;
        if (accept) begin
            op_d  = alu_control_lines;
            cnt_d = shamt;
            ill_d = !is_legal(alu_control_lines);
            res_d = is_shift(alu_control_lines) ? operand_a : lu_y;
        end else if (state_q == ST_SHIFT) begin
            cnt_d = cnt_q - SHAMT_W'(1);
            unique case (op_q)
                OP_SLL:  res_d = {res_q[WIDTH-2:0], 1'b0};
                OP_SRA:  res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
                default: res_d = {1'b0, res_q[WIDTH-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            res_q <= '0;
            cnt_q <= '0;
            ill_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            ill_q <= ill_d;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed table, corner sequences and random commands for
// multicycle_alu, checked against an arithmetic reference model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ctl = '0;
    logic [31:0] oa = '0;
    logic [31:0] ob = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    multicycle_alu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_control_lines (ctl),
        .operand_a         (oa),
        .operand_b         (ob),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .result            (result),
        .zero              (zero),
        .illegal           (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the whole operand, latency from amount.
    task automatic model(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic ill, output int lat);
        int k;
        k   = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a + b;
            4'd3: r = a ^ b;
            4'd4: r = a << k;
            4'd5: r = $signed(a) >>> k;
            4'd6: r = a - b;
            4'd7: r = a >> k;
            default: begin
                r   = '0;
                ill = 1'b1;
            end
        endcase
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && k != 0) lat = k + 1;
    endtask

    // Called at a negedge with the block idle.
    task automatic run(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ei, input int el);
        int lat;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ctl = op;
        oa = a;
        ob = b;
        @(negedge clk);
        in_valid = 1'b0;
        ctl = 4'($urandom);
        oa = $urandom;
        ob = $urandom;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(el));
        chk({name, " result"}, result, er);
        chk({name, " zero"}, 32'(zero), 32'(er == 32'd0));
        chk({name, " illegal"}, 32'(illegal), 32'(ei));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb, rr;
        logic        ri;
        int          rl;

        vecs[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1};
        vecs[1]  = '{4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1};
        vecs[2]  = '{4'b0101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 5};
        vecs[3]  = '{4'b0111, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 5};
        vecs[4]  = '{4'b0100, 32'h1, 32'd31, 32'h80000000, 1'b0, 32};
        vecs[5]  = '{4'b1111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1};
        vecs[6]  = '{4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1};
        vecs[7]  = '{4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1};
        vecs[8]  = '{4'b0011, 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0, 1};
        vecs[9]  = '{4'b0100, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF, 1'b0, 1};
        vecs[10] = '{4'b1000, 32'hFFFF, 32'h1, 32'h0, 1'b1, 1};
        vecs[11] = '{4'b0101, 32'h7FFFFFFF, 32'd31, 32'h0, 1'b0, 32};

        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", 32'(zero), 32'd1);
        chk("reset illegal", 32'(illegal), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].r, vecs[i].ill, vecs[i].lat);
        end

        // Illegal result must hold while the consumer stalls.
        in_valid = 1'b1;
        ctl = 4'b1111;
        oa = 32'hFFFF;
        ob = 32'h3;
        @(negedge clk);
        in_valid = 1'b0;
        oa = 32'h1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d result", c), result, 32'd0);
            chk($sformatf("stall%0d illegal", c), 32'(illegal), 32'd1);
            chk($sformatf("stall%0d zero", c), 32'(zero), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall release in_ready", 32'(in_ready), 32'd1);
        chk("stall release valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a long shift discards it.
        in_valid = 1'b1;
        ctl = 4'b0100;
        oa = 32'h3;
        ob = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midshift busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midshift rst valid", 32'(out_valid), 32'd0);
        chk("midshift rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("after rst in_ready", 32'(in_ready), 32'd1);
        chk("after rst valid", 32'(out_valid), 32'd0);
        run("post reset and", 4'b0000, 32'hF0, 32'h3C, 32'h30, 1'b0, 1);

        for (int n = 0; n < 150; n++) begin
            rop = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7))
                                             : 4'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) ra = 32'h80000000 | ra;
            model(rop, ra, rb, rr, ri, rl);
            run($sformatf("rand%0d op%0h", n, rop), rop, ra, rb, rr, ri, rl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
